// File: rtl/store_rmw_pkg.sv
// Shared store-type codes, FSM state encoding and size helper for the store RMW engine.
package store_rmw_pkg;

    localparam logic [1:0] ST_SB = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SW = 2'd2;
    localparam logic [1:0] ST_SD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    function automatic int size_bytes(input logic [1:0] st_type);
        int sz;
        case (st_type)
            ST_SB:   sz = 1;
            ST_SH:   sz = 2;
            ST_SW:   sz = 4;
            default: sz = 8;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge: drops the low size bytes of data into old_word at offset.
module store_lane_merge
    import store_rmw_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        st_type,
    input  logic [OFF_W-1:0]  offset,
    output logic [DATA_W-1:0] merged
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] data_sh;
    logic [NB-1:0]     lane_en;
    int                lane_lo;
    int                lane_hi;

    always_comb begin
        data_sh = data << {offset, 3'b000};
        lane_lo = int'(offset);
        lane_hi = lane_lo + size_bytes(st_type);
        for (int i = 0; i < int'(NB); i++) begin
            lane_en[i] = (i >= lane_lo) && (i < lane_hi);
        end
        for (int i = 0; i < int'(NB); i++) begin
            merged[i*8 +: 8] = lane_en[i] ? data_sh[i*8 +: 8] : old_word[i*8 +: 8];
        end
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Read-modify-write store engine for a data memory without byte enables.
// Define STORE_RMW_MISALIGN_TRAP_EN to reject misaligned/illegal stores via the error path.
module store_rmw_unit
    import store_rmw_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_type,
    output logic              mem_rd_en,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              done,
    output logic              err
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        type_q, type_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic [1:0]        req_type_eff;
    logic [OFF_W-1:0]  req_off, req_mask, req_off_eff;
    logic              req_full;
    logic [DATA_W-1:0] merged;
`ifdef STORE_RMW_MISALIGN_TRAP_EN
    logic              req_misalign;
    logic              err_q, err_d;
`endif

    // Decode the incoming request: effective type, naturally aligned offset, full-width flag.
    always_comb begin
        req_type_eff = req_type;
`ifndef STORE_RMW_MISALIGN_TRAP_EN
        if (DATA_W == 32 && req_type == ST_SD) req_type_eff = ST_SW;
`endif
        req_off     = req_addr[OFF_W-1:0];
        req_mask    = OFF_W'(size_bytes(req_type_eff) - 1);
        req_off_eff = req_off & ~req_mask;
        req_full    = size_bytes(req_type_eff) == int'(DATA_W / 8);
`ifdef STORE_RMW_MISALIGN_TRAP_EN
        req_misalign = ((req_off & req_mask) != '0) || (DATA_W == 32 && req_type == ST_SD);
`endif
    end

    store_lane_merge #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_merge (
        .old_word (mem_rd_data),
        .data     (data_q),
        .st_type  (type_q),
        .offset   (addr_q[OFF_W-1:0]),
        .merged   (merged)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        type_d  = type_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = {req_addr[ADDR_W-1:OFF_W], req_off_eff};
                    data_d  = req_data;
                    type_d  = req_type_eff;
                    state_d = req_full ? S_WRITE : S_RD;
`ifdef STORE_RMW_MISALIGN_TRAP_EN
                    if (req_misalign) state_d = S_ERR;
`endif
                end
            end
            S_RD:    state_d = S_WAIT;
            S_WAIT:  if (mem_rd_valid) state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered decodes of the state being entered.
        rd_en_d   = (state_d == S_RD);
        wr_en_d   = (state_d == S_WRITE);
        done_d    = (state_d == S_WRITE) || (state_d == S_ERR);
        wr_data_d = '0;
        if (state_d == S_WRITE) wr_data_d = (state_q == S_WAIT) ? merged : data_d;
        mem_addr_d = '0;
        if (state_d == S_RD || state_d == S_WAIT || state_d == S_WRITE) begin
            mem_addr_d = {addr_d[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
`ifdef STORE_RMW_MISALIGN_TRAP_EN
        err_d = (state_d == S_ERR);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            type_q     <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            wr_data_q  <= '0;
            mem_addr_q <= '0;
`ifdef STORE_RMW_MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            type_q     <= type_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            wr_data_q  <= wr_data_d;
            mem_addr_q <= mem_addr_d;
`ifdef STORE_RMW_MISALIGN_TRAP_EN
            err_q      <= err_d;
`endif
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = wr_data_q;
    assign mem_addr    = mem_addr_q;
    assign done        = done_q;
`ifdef STORE_RMW_MISALIGN_TRAP_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit: 32-bit and 64-bit instances, vector table,
// random stores against a byte-array memory model, and reset/latency corner sequences.
module tb_store_rmw_unit;
    import store_rmw_pkg::*;

`ifdef STORE_RMW_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance (a)
    logic        req_valid_a, req_ready_a, mem_rd_en_a, mem_rd_valid_a, mem_wr_en_a, done_a, err_a;
    logic [31:0] req_addr_a, req_data_a, mem_rd_data_a, mem_wr_data_a, mem_addr_a;
    logic [1:0]  req_type_a;
    // 64-bit instance (b)
    logic        req_valid_b, req_ready_b, mem_rd_en_b, mem_rd_valid_b, mem_wr_en_b, done_b, err_b;
    logic [31:0] req_addr_b, mem_addr_b;
    logic [63:0] req_data_b, mem_rd_data_b, mem_wr_data_b;
    logic [1:0]  req_type_b;

    store_rmw_unit #(.DATA_W(32), .ADDR_W(32)) u_dut_a (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid_a), .req_ready (req_ready_a), .req_addr (req_addr_a),
        .req_data (req_data_a), .req_type (req_type_a),
        .mem_rd_en (mem_rd_en_a), .mem_rd_valid (mem_rd_valid_a), .mem_rd_data (mem_rd_data_a),
        .mem_wr_en (mem_wr_en_a), .mem_wr_data (mem_wr_data_a), .mem_addr (mem_addr_a),
        .done (done_a), .err (err_a)
    );

    store_rmw_unit #(.DATA_W(64), .ADDR_W(32)) u_dut_b (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid_b), .req_ready (req_ready_b), .req_addr (req_addr_b),
        .req_data (req_data_b), .req_type (req_type_b),
        .mem_rd_en (mem_rd_en_b), .mem_rd_valid (mem_rd_valid_b), .mem_rd_data (mem_rd_data_b),
        .mem_wr_en (mem_wr_en_b), .mem_wr_data (mem_wr_data_b), .mem_addr (mem_addr_b),
        .done (done_b), .err (err_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Runs one store on the selected instance, acting as the memory with latency lat.
    task automatic run(input bit w64, input logic [31:0] addr, input logic [63:0] data,
                       input logic [1:0] typ, input logic [63:0] rd_word, input int lat,
                       output logic [63:0] wdata, output logic [63:0] waddr, output int rds,
                       output int wrs, output logic gerr, output int dcyc, output int busy_rdy);
        int due;
        bit fin;
        logic s_rd, s_wr, s_done, s_err, s_rdy;
        logic [63:0] s_wdata, s_addr;
        wdata = '0; waddr = '0; rds = 0; wrs = 0; gerr = 1'b0; dcyc = -1; busy_rdy = 0;
        due = -1; fin = 1'b0;
        @(negedge clk);
        if (w64) begin
            req_valid_b = 1'b1; req_addr_b = addr; req_data_b = data; req_type_b = typ;
        end else begin
            req_valid_a = 1'b1; req_addr_a = addr; req_data_a = data[31:0]; req_type_a = typ;
        end
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            s_rd    = w64 ? mem_rd_en_b : mem_rd_en_a;
            s_wr    = w64 ? mem_wr_en_b : mem_wr_en_a;
            s_done  = w64 ? done_b : done_a;
            s_err   = w64 ? err_b : err_a;
            s_rdy   = w64 ? req_ready_b : req_ready_a;
            s_wdata = w64 ? mem_wr_data_b : {32'h0, mem_wr_data_a};
            s_addr  = w64 ? {32'h0, mem_addr_b} : {32'h0, mem_addr_a};
            if (s_rd) begin rds++; due = c + lat; waddr = s_addr; end
            if (s_wr) begin wrs++; wdata = s_wdata; waddr = s_addr; end
            if (s_done) begin gerr = s_err; dcyc = c; fin = 1'b1; end
            if (s_rdy) busy_rdy++;
            mem_rd_valid_a = !w64 && (c == due);
            mem_rd_valid_b = w64 && (c == due);
            mem_rd_data_a  = rd_word[31:0];
            mem_rd_data_b  = rd_word;
            @(posedge clk); #1;
        end
        mem_rd_valid_a = 1'b0; mem_rd_valid_b = 1'b0;
    endtask

    typedef struct {
        bit          w64;
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  typ;
        logic [63:0] rd_word;
        int          lat;
        logic [63:0] exp_wdata;
        logic [63:0] exp_addr;
        int          exp_rds;
        int          exp_wrs;
        logic        exp_err;
        int          exp_cycle;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] bmem [64];

    initial begin
        logic [63:0] wd, wa;
        int rds, wrs, dc, br, cnt_wr, cnt_done, cnt_act;
        logic ge;

        req_valid_a = 0; req_addr_a = 0; req_data_a = 0; req_type_a = 0;
        mem_rd_valid_a = 0; mem_rd_data_a = 0;
        req_valid_b = 0; req_addr_b = 0; req_data_b = 0; req_type_b = 0;
        mem_rd_valid_b = 0; mem_rd_data_b = 0;

        // Reset values
        #12;
        check("rst_ready", {63'h0, req_ready_a}, 64'h1);
        check("rst_rd_en", {63'h0, mem_rd_en_a}, 64'h0);
        check("rst_wr_en", {63'h0, mem_wr_en_a}, 64'h0);
        check("rst_done", {63'h0, done_a | err_a}, 64'h0);
        check("rst_wdata", {32'h0, mem_wr_data_a}, 64'h0);
        check("rst_addr", {32'h0, mem_addr_a}, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        // Vector table
        vecs.push_back('{0, 32'h1003, 64'hAB, ST_SB, 64'h11223344, 1,
                         64'hAB223344, 64'h1000, 1, 1, 1'b0, 3});
        vecs.push_back('{0, 32'h2000, 64'hDEADBEEF, ST_SW, 64'h0, 1,
                         64'hDEADBEEF, 64'h2000, 0, 1, 1'b0, 1});
        if (TRAP) vecs.push_back('{0, 32'h1001, 64'h5A5A, ST_SH, 64'h11223344, 1,
                                   64'h0, 64'h0, 0, 0, 1'b1, 1});
        else      vecs.push_back('{0, 32'h1001, 64'h5A5A, ST_SH, 64'h11223344, 1,
                                   64'h11225A5A, 64'h1000, 1, 1, 1'b0, 3});
        vecs.push_back('{0, 32'h3002, 64'hFFFFBEEF, ST_SH, 64'h11223344, 2,
                         64'hBEEF3344, 64'h3000, 1, 1, 1'b0, 4});
        vecs.push_back('{0, 32'h4000, 64'h12345678, ST_SB, 64'hAABBCCDD, 1,
                         64'hAABBCC78, 64'h4000, 1, 1, 1'b0, 3});
        vecs.push_back('{0, 32'h4001, 64'h99, ST_SB, 64'hAABBCCDD, 3,
                         64'hAABB99DD, 64'h4000, 1, 1, 1'b0, 5});
        if (TRAP) vecs.push_back('{0, 32'h5006, 64'hCAFEF00D, ST_SD, 64'h0, 1,
                                   64'h0, 64'h0, 0, 0, 1'b1, 1});
        else      vecs.push_back('{0, 32'h5006, 64'hCAFEF00D, ST_SD, 64'h0, 1,
                                   64'hCAFEF00D, 64'h5004, 0, 1, 1'b0, 1});
        if (TRAP) vecs.push_back('{0, 32'h6003, 64'h01020304, ST_SW, 64'h0, 1,
                                   64'h0, 64'h0, 0, 0, 1'b1, 1});
        else      vecs.push_back('{0, 32'h6003, 64'h01020304, ST_SW, 64'h0, 1,
                                   64'h01020304, 64'h6000, 0, 1, 1'b0, 1});
        vecs.push_back('{1, 32'h06, 64'h5A5A, ST_SH, 64'h0123456789ABCDEF, 1,
                         64'h5A5A456789ABCDEF, 64'h0, 1, 1, 1'b0, 3});
        vecs.push_back('{1, 32'h10, 64'h1122334455667788, ST_SD, 64'h0, 1,
                         64'h1122334455667788, 64'h10, 0, 1, 1'b0, 1});
        vecs.push_back('{1, 32'h0C, 64'hDEADBEEF, ST_SW, 64'h0123456789ABCDEF, 2,
                         64'hDEADBEEF89ABCDEF, 64'h8, 1, 1, 1'b0, 4});

        foreach (vecs[i]) begin
            run(vecs[i].w64, vecs[i].addr, vecs[i].data, vecs[i].typ, vecs[i].rd_word,
                vecs[i].lat, wd, wa, rds, wrs, ge, dc, br);
            check($sformatf("v%0d_err", i), {63'h0, ge}, {63'h0, vecs[i].exp_err});
            check($sformatf("v%0d_wdata", i), wd, vecs[i].exp_wdata);
            check($sformatf("v%0d_addr", i), wa, vecs[i].exp_addr);
            check($sformatf("v%0d_rds", i), 64'(rds), 64'(vecs[i].exp_rds));
            check($sformatf("v%0d_wrs", i), 64'(wrs), 64'(vecs[i].exp_wrs));
            check($sformatf("v%0d_cycle", i), 64'(dc), 64'(vecs[i].exp_cycle));
            check($sformatf("v%0d_busy_ready", i), 64'(br), 64'h0);
        end

        // Spurious read-valid pulse while idle must be ignored
        @(negedge clk); mem_rd_valid_a = 1'b1; mem_rd_data_a = 32'hFFFFFFFF;
        @(negedge clk); mem_rd_valid_a = 1'b0;
        cnt_act = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (mem_rd_en_a || mem_wr_en_a || done_a || !req_ready_a) cnt_act++;
        end
        check("spurious_idle", 64'(cnt_act), 64'h0);

        // Long read latency: one read, one write, ready low throughout
        run(0, 32'h1002, 64'h7777, ST_SH, 64'hAABBCCDD, 5, wd, wa, rds, wrs, ge, dc, br);
        check("lat5_wdata", wd, 64'h7777CCDD);
        check("lat5_rds", 64'(rds), 64'h1);
        check("lat5_wrs", 64'(wrs), 64'h1);
        check("lat5_cycle", 64'(dc), 64'h7);
        check("lat5_busy_ready", 64'(br), 64'h0);

        // Reset while waiting for read data
        @(negedge clk);
        req_valid_a = 1'b1; req_addr_a = 32'h1003; req_data_a = 32'hAB; req_type_a = ST_SB;
        @(posedge clk); #1; req_valid_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check("wait_rst_ready", {63'h0, req_ready_a}, 64'h1);
        check("wait_rst_strobes", {61'h0, mem_rd_en_a, mem_wr_en_a, done_a}, 64'h0);
        check("wait_rst_addr", {32'h0, mem_addr_a}, 64'h0);
        check("wait_rst_wdata", {32'h0, mem_wr_data_a}, 64'h0);
        mem_rd_valid_a = 1'b1; mem_rd_data_a = 32'h11223344;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); mem_rd_valid_a = 1'b0;
        cnt_wr = 0; cnt_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (mem_wr_en_a || mem_rd_en_a) cnt_wr++;
            if (done_a) cnt_done++;
        end
        check("wait_rst_no_write", 64'(cnt_wr), 64'h0);
        check("wait_rst_no_done", 64'(cnt_done), 64'h0);
        check("wait_rst_ready_after", {63'h0, req_ready_a}, 64'h1);

        // Random stores against a byte-addressed memory model
        foreach (bmem[i]) bmem[i] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            int w, off, sz, aoff, lat;
            logic [1:0] t;
            logic [31:0] d, old, expw;
            bit e;
            w = $urandom_range(15); off = $urandom_range(3); t = 2'($urandom_range(3));
            d = $urandom; lat = $urandom_range(4, 1);
            old = {bmem[w*4+3], bmem[w*4+2], bmem[w*4+1], bmem[w*4]};
            sz = (t == ST_SB) ? 1 : (t == ST_SH) ? 2 : 4;
            e = TRAP && (((off % sz) != 0) || (t == ST_SD));
            aoff = off - (off % sz);
            if (!e) for (int b = 0; b < sz; b++) bmem[w*4 + aoff + b] = d[8*b +: 8];
            expw = {bmem[w*4+3], bmem[w*4+2], bmem[w*4+1], bmem[w*4]};
            run(0, 32'(32'h100 + w*4 + off), {32'h0, d}, t, {32'h0, old}, lat,
                wd, wa, rds, wrs, ge, dc, br);
            check($sformatf("r%0d_err", n), {63'h0, ge}, {63'h0, e});
            if (!e) check($sformatf("r%0d_wdata", n), wd, {32'h0, expw});
            check($sformatf("r%0d_addr", n), wa, e ? 64'h0 : 64'(32'h100 + w*4));
            check($sformatf("r%0d_wrs", n), 64'(wrs), e ? 64'h0 : 64'h1);
            check($sformatf("r%0d_rds", n), 64'(rds), (e || sz == 4) ? 64'h0 : 64'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
